// File: rtl/debug_unit_ctrl.sv
// Debug unit controller: host byte commands load imem, run or single-step the pipeline, then dump state over UART TX.
// Optional feature macro DU_CYCLE_COUNT_EN appends a 32-bit count of read_en cycles to every dump.
module debug_unit_ctrl #(
  parameter int unsigned MEM_DUMP_WORDS = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [7:0]   i_rx_data,
  input  logic         i_rx_valid,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_start,
  input  logic         i_tx_busy,
  output logic [31:0]  o_du_data,
  output logic [31:0]  o_du_inst_addr_wr,
  output logic         o_du_write_en,
  output logic         o_du_read_en,
  input  logic         i_du_halt,
  input  logic [63:0]  i_du_if_id_data,
  input  logic [129:0] i_du_id_ex_data,
  input  logic [75:0]  i_du_ex_m_data,
  input  logic [70:0]  i_du_m_wb_data,
  input  logic [31:0]  i_du_regs_mem_data,
  input  logic [31:0]  i_du_mem_data
);

  localparam int unsigned LatchBits  = 352;
  localparam int unsigned LatchWords = LatchBits / 32;
  localparam int unsigned NumRegs    = 32;

  localparam logic [7:0] CmdLoad   = 8'h4C;
  localparam logic [7:0] CmdRun    = 8'h52;
  localparam logic [7:0] CmdStep   = 8'h53;
  localparam logic [7:0] AckByte   = 8'h4B;
  localparam logic [3:0] LastLatch = 4'(LatchWords - 1);
  localparam logic [7:0] LastReg   = 8'(NumRegs - 1);
  localparam logic [7:0] LastMem   = 8'(MEM_DUMP_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, SNAP,
    DUMP_LATCH, DUMP_REG, DUMP_MEM, TX_BYTE, TX_WAIT
  } state_t;

  state_t state, state_nxt, ret_state;

  logic [31:0]          word_buf;
  logic [31:0]          word_nxt;
  logic [1:0]           byte_cnt;
  logic [7:0]           word_idx;
  logic [7:0]           word_cnt;
  logic                 ld_last;
  logic [LatchBits-1:0] lat_buf;
  logic [3:0]           lat_cnt;
  logic [7:0]           dump_idx;
  logic                 addr_wait;
  logic [31:0]          tx_q;
  logic [2:0]           tx_left;
  logic                 tx_skip;
  logic                 tx_fire;
  logic                 tx_done;

  logic [7:0]  tx_data_d;
  logic        tx_start_d;
  logic [31:0] du_data_d;
  logic [31:0] du_addr_d;
  logic        write_en_d;
  logic        read_en_d;

`ifdef DU_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;
  logic        cnt_phase;
`endif

  assign word_nxt = {word_buf[23:0], i_rx_data};
  assign ld_last  = (8'(word_idx + 8'd1) == word_cnt);
  assign tx_fire  = (state == TX_BYTE) && !i_tx_busy;
  assign tx_done  = (state == TX_WAIT) && !tx_skip && !i_tx_busy;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CmdLoad: state_nxt = LD_CNT;
            CmdRun:  state_nxt = i_du_halt ? SNAP : RUN;
            CmdStep: state_nxt = i_du_halt ? SNAP : STEP;
            default: state_nxt = IDLE;
          endcase
        end
      end
      LD_CNT:     if (i_rx_valid) state_nxt = (i_rx_data == 8'd0) ? TX_BYTE : LD_BYTE;
      LD_BYTE:    if (i_rx_valid && byte_cnt == 2'd3) state_nxt = LD_WR;
      LD_WR:      state_nxt = ld_last ? TX_BYTE : LD_BYTE;
      RUN:        if (i_du_halt) state_nxt = SNAP;
      STEP:       state_nxt = SNAP;
      SNAP:       state_nxt = DUMP_LATCH;
      DUMP_LATCH: state_nxt = TX_BYTE;
      DUMP_REG:   if (addr_wait) state_nxt = TX_BYTE;
`ifdef DU_CYCLE_COUNT_EN
      DUMP_MEM:   if (addr_wait || cnt_phase) state_nxt = TX_BYTE;
`else
      DUMP_MEM:   if (addr_wait) state_nxt = TX_BYTE;
`endif
      TX_BYTE:    if (!i_tx_busy) state_nxt = TX_WAIT;
      TX_WAIT:    if (tx_done) state_nxt = (tx_left != 3'd0) ? TX_BYTE : ret_state;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs, keyed on the upcoming state
  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = o_tx_data;
    du_data_d  = o_du_data;
    du_addr_d  = o_du_inst_addr_wr;
    write_en_d = 1'b0;
    read_en_d  = 1'b0;
    if (tx_fire) begin
      tx_start_d = 1'b1;
      tx_data_d  = tx_q[31:24];
    end
    case (state_nxt)
      IDLE: du_addr_d = '0;
      LD_WR: begin
        write_en_d = 1'b1;
        du_data_d  = word_nxt;
        du_addr_d  = {22'd0, word_idx, 2'b00};
      end
      RUN, STEP:          read_en_d = 1'b1;
      DUMP_REG, DUMP_MEM: du_addr_d = {24'd0, dump_idx};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_tx_data         <= '0;
      o_tx_start        <= 1'b0;
      o_du_data         <= '0;
      o_du_inst_addr_wr <= '0;
      o_du_write_en     <= 1'b0;
      o_du_read_en      <= 1'b0;
    end else begin
      o_tx_data         <= tx_data_d;
      o_tx_start        <= tx_start_d;
      o_du_data         <= du_data_d;
      o_du_inst_addr_wr <= du_addr_d;
      o_du_write_en     <= write_en_d;
      o_du_read_en      <= read_en_d;
    end
  end

  // Datapath: load assembly, latch snapshot, dump sequencing and the TX byte queue
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_buf  <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      word_cnt  <= '0;
      lat_buf   <= '0;
      lat_cnt   <= '0;
      dump_idx  <= '0;
      addr_wait <= 1'b0;
      tx_q      <= '0;
      tx_left   <= '0;
      tx_skip   <= 1'b0;
      ret_state <= IDLE;
`ifdef DU_CYCLE_COUNT_EN
      cnt_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_rx_valid && i_rx_data == CmdLoad) begin
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        LD_CNT: begin
          if (i_rx_valid) begin
            word_cnt <= i_rx_data;
            if (i_rx_data == 8'd0) begin
              tx_q      <= {AckByte, 24'd0};
              tx_left   <= 3'd1;
              ret_state <= IDLE;
            end
          end
        end
        LD_BYTE: begin
          if (i_rx_valid) begin
            word_buf <= word_nxt;
            byte_cnt <= 2'(byte_cnt + 2'd1);
          end
        end
        LD_WR: begin
          word_idx <= 8'(word_idx + 8'd1);
          if (ld_last) begin
            tx_q      <= {AckByte, 24'd0};
            tx_left   <= 3'd1;
            ret_state <= IDLE;
          end
        end
        SNAP: begin
          lat_buf   <= {i_du_if_id_data, 6'd0, i_du_id_ex_data, 4'd0,
                        i_du_ex_m_data, 1'b0, i_du_m_wb_data};
          lat_cnt   <= '0;
          dump_idx  <= '0;
          addr_wait <= 1'b0;
        end
        DUMP_LATCH: begin
          tx_q      <= lat_buf[LatchBits-1 -: 32];
          lat_buf   <= lat_buf << 32;
          tx_left   <= 3'd4;
          lat_cnt   <= 4'(lat_cnt + 4'd1);
          ret_state <= (lat_cnt == LastLatch) ? DUMP_REG : DUMP_LATCH;
        end
        DUMP_REG: begin
          if (!addr_wait) begin
            addr_wait <= 1'b1;
          end else begin
            addr_wait <= 1'b0;
            tx_q      <= i_du_regs_mem_data;
            tx_left   <= 3'd4;
            if (dump_idx == LastReg) begin
              dump_idx  <= '0;
              ret_state <= DUMP_MEM;
            end else begin
              dump_idx  <= 8'(dump_idx + 8'd1);
              ret_state <= DUMP_REG;
            end
          end
        end
        DUMP_MEM: begin
`ifdef DU_CYCLE_COUNT_EN
          if (cnt_phase) begin
            cnt_phase <= 1'b0;
            tx_q      <= cycle_cnt;
            tx_left   <= 3'd4;
            ret_state <= IDLE;
          end else
`endif
          if (!addr_wait) begin
            addr_wait <= 1'b1;
          end else begin
            addr_wait <= 1'b0;
            tx_q      <= i_du_mem_data;
            tx_left   <= 3'd4;
            if (dump_idx == LastMem) begin
              dump_idx  <= '0;
`ifdef DU_CYCLE_COUNT_EN
              cnt_phase <= 1'b1;
              ret_state <= DUMP_MEM;
`else
              ret_state <= IDLE;
`endif
            end else begin
              dump_idx  <= 8'(dump_idx + 8'd1);
              ret_state <= DUMP_MEM;
            end
          end
        end
        TX_BYTE: begin
          if (!i_tx_busy) begin
            tx_q    <= tx_q << 8;
            tx_left <= 3'(tx_left - 3'd1);
            tx_skip <= 1'b1;
          end
        end
        TX_WAIT: tx_skip <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef DU_CYCLE_COUNT_EN
  // Pipeline-advance cycle counter; a load command starts a fresh measurement
  always_ff @(posedge i_clk) begin
    if (i_reset || (state == IDLE && i_rx_valid && i_rx_data == CmdLoad)) cycle_cnt <= '0;
    else if (o_du_read_en)                                                cycle_cnt <= 32'(cycle_cnt + 32'd1);
  end
`endif

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Bench for debug_unit_ctrl: TX bytes and imem writes are scoreboarded against a small pipeline/UART model.
// Build with +define+DU_CYCLE_COUNT_EN to cover the cycle-count trailer.
`timescale 1ns/1ps
module tb_debug_unit_ctrl;

  localparam int unsigned MemWords   = 32;
  localparam int unsigned BusyCycles = 3;
  localparam int unsigned Timeout    = 20000;
`ifdef DU_CYCLE_COUNT_EN
  localparam int unsigned DumpBytes = 172 + 4 * MemWords + 4;
`else
  localparam int unsigned DumpBytes = 172 + 4 * MemWords;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         tx_busy;
  logic [31:0]  du_data;
  logic [31:0]  du_addr;
  logic         du_write_en;
  logic         du_read_en;
  logic         du_halt;
  logic [63:0]  if_id;
  logic [129:0] id_ex;
  logic [75:0]  ex_m;
  logic [70:0]  m_wb;
  logic [31:0]  regs_q;
  logic [31:0]  mem_q;

  always #5 clk = ~clk;

  debug_unit_ctrl #(.MEM_DUMP_WORDS(MemWords)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_rx_data          (rx_data),
    .i_rx_valid         (rx_valid),
    .o_tx_data          (tx_data),
    .o_tx_start         (tx_start),
    .i_tx_busy          (tx_busy),
    .o_du_data          (du_data),
    .o_du_inst_addr_wr  (du_addr),
    .o_du_write_en      (du_write_en),
    .o_du_read_en       (du_read_en),
    .i_du_halt          (du_halt),
    .i_du_if_id_data    (if_id),
    .i_du_id_ex_data    (id_ex),
    .i_du_ex_m_data     (ex_m),
    .i_du_m_wb_data     (m_wb),
    .i_du_regs_mem_data (regs_q),
    .i_du_mem_data      (mem_q)
  );

  // Pipeline model: halts once it has advanced halt_at times; reg/mem reads have one cycle latency
  logic [31:0] regs [32];
  logic [31:0] mem  [256];
  int unsigned adv = 0;
  int unsigned halt_at = 1000;
  assign du_halt = (adv >= halt_at);
  always @(posedge clk) begin
    if (du_read_en) adv <= adv + 1;
    regs_q <= regs[du_addr[4:0]];
    mem_q  <= mem[du_addr[7:0]];
  end

  // UART TX model: busy for BusyCycles starting the cycle after a start pulse
  int unsigned busy_cnt = 0;
  logic force_busy;
  always @(posedge clk) begin
    if (reset)              busy_cnt <= 0;
    else if (tx_start)      busy_cnt <= BusyCycles;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0]  exp_tx[$];
  logic [63:0] exp_wr[$];
  logic [7:0]  tx_log[$];
  int tx_total = 0, wr_total = 0, re_total = 0;
  int tx_extra = 0, wr_extra = 0, overlap = 0;
  logic [31:0] exp_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    logic [63:0] w;
    if (!reset) begin
      if (tx_start) begin
        tx_total++;
        tx_log.push_back(tx_data);
        if (exp_tx.size() == 0) tx_extra++;
        else check_eq("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
      end
      if (du_write_en) begin
        wr_total++;
        if (exp_wr.size() == 0) wr_extra++;
        else begin
          w = exp_wr.pop_front();
          check_eq("wr_addr", 64'(du_addr), 64'(w[63:32]));
          check_eq("wr_data", 64'(du_data), 64'(w[31:0]));
        end
      end
      if (du_read_en) re_total++;
      if (du_read_en && du_write_en) overlap++;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_dump();
    logic [351:0] lat;
    lat = {if_id, 6'd0, id_ex, 4'd0, ex_m, 1'b0, m_wb};
    for (int i = 43; i >= 0; i--) exp_tx.push_back(lat[i*8 +: 8]);
    for (int r = 0; r < 32; r++) push_word(regs[r]);
    for (int m = 0; m < int'(MemWords); m++) push_word(mem[m]);
`ifdef DU_CYCLE_COUNT_EN
    push_word(exp_cyc);
`endif
  endtask

  task automatic randomize_latches();
    if_id = {$urandom, $urandom};
    id_ex = {$urandom, $urandom, $urandom, $urandom, $urandom};
    ex_m  = {$urandom, $urandom, $urandom};
    m_wb  = {$urandom, $urandom, $urandom};
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < int'(Timeout)) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_done", 64'(exp_tx.size() + exp_wr.size()), 64'd0);
    repeat (BusyCycles + 8) @(negedge clk);
  endtask

  initial begin
    int tx_mark, re_mark, wr_mark, n, bp_starts, bp_changes;
    logic [7:0] bp_data;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; force_busy = 1'b0;
    for (int r = 0; r < 32; r++)  regs[r] = $urandom;
    for (int m = 0; m < 256; m++) mem[m]  = $urandom;
    regs[3] = 32'hFFFF_FFFF;
    randomize_latches();

    // Reset: two cycles, with a run command arriving during reset
    @(negedge clk);
    rx_data = 8'h52; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check_eq("rst_tx_start", 64'(tx_start), 64'd0);
    check_eq("rst_tx_data",  64'(tx_data), 64'd0);
    check_eq("rst_du_data",  64'(du_data), 64'd0);
    check_eq("rst_addr",     64'(du_addr), 64'd0);
    check_eq("rst_write_en", 64'(du_write_en), 64'd0);
    check_eq("rst_read_en",  64'(du_read_en), 64'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_no_read_en", 64'(re_total), 64'd0);
    check_eq("rst_no_tx", 64'(tx_total), 64'd0);

    // Load two words
    exp_wr.push_back({32'h0, 32'h2443_FFFF});
    exp_wr.push_back({32'h4, 32'hFC00_0000});
    exp_tx.push_back(8'h4B);
    exp_cyc = 0;
    send_rx(8'h4C); send_rx(8'h02);
    send_rx(8'h24); send_rx(8'h43); send_rx(8'hFF); send_rx(8'hFF);
    send_rx(8'hFC); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00);
    wait_drain();
    check_eq("load_writes", 64'(wr_total), 64'd2);
    check_eq("load_idle_addr", 64'(du_addr), 64'd0);

    // Run to halt after five advances: read_en stays up one more cycle
    tx_mark = tx_total; re_mark = re_total;
    halt_at = adv + 5;
    exp_cyc = exp_cyc + 6;
    push_dump();
    send_rx(8'h52);
    wait_drain();
    check_eq("run_read_en_cycles", 64'(re_total - re_mark), 64'd6);
    check_eq("run_dump_bytes", 64'(tx_total - tx_mark), 64'(DumpBytes));
    check_eq("run_reg3_byte", 64'(tx_log[tx_mark + 44 + 12]), 64'hFF);
    check_eq("run_idle_addr", 64'(du_addr), 64'd0);

    // Single step with halt low
    randomize_latches();
    tx_mark = tx_total; re_mark = re_total;
    halt_at = adv + 1000;
    exp_cyc = exp_cyc + 1;
    push_dump();
    send_rx(8'h53);
    wait_drain();
    check_eq("step_read_en_cycles", 64'(re_total - re_mark), 64'd1);
    check_eq("step_first_byte", 64'(tx_log[tx_mark]), 64'(if_id[63:56]));
    check_eq("step_dump_bytes", 64'(tx_total - tx_mark), 64'(DumpBytes));

    // Empty load, unknown command, run while already halted
    wr_mark = wr_total;
    exp_tx.push_back(8'h4B);
    exp_cyc = 0;
    send_rx(8'h4C); send_rx(8'h00);
    wait_drain();
    check_eq("empty_load_writes", 64'(wr_total - wr_mark), 64'd0);
    tx_mark = tx_total;
    send_rx(8'h41);
    repeat (20) @(negedge clk);
    check_eq("ignored_cmd_tx", 64'(tx_total - tx_mark), 64'd0);
    check_eq("ignored_cmd_addr", 64'(du_addr), 64'd0);
    randomize_latches();
    tx_mark = tx_total; re_mark = re_total;
    halt_at = adv;
    push_dump();
    send_rx(8'h52);
    wait_drain();
    check_eq("halted_run_read_en", 64'(re_total - re_mark), 64'd0);
    check_eq("halted_run_dump_bytes", 64'(tx_total - tx_mark), 64'(DumpBytes));

    // Step dump with the TX side stalled for 50 cycles mid-stream
    randomize_latches();
    tx_mark = tx_total; re_mark = re_total;
    halt_at = adv + 1000;
    exp_cyc = exp_cyc + 1;
    push_dump();
    send_rx(8'h53);
    n = 0;
    while (tx_total < tx_mark + 10 && n < int'(Timeout)) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_reached", 64'(tx_total >= tx_mark + 10), 64'd1);
    bp_data = tx_data;
    force_busy = 1'b1;
    bp_starts = 0; bp_changes = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_start) bp_starts++;
      if (tx_data != bp_data) bp_changes++;
    end
    force_busy = 1'b0;
    check_eq("bp_no_start", 64'(bp_starts), 64'd0);
    check_eq("bp_data_stable", 64'(bp_changes), 64'd0);
    wait_drain();
    check_eq("bp_read_en_cycles", 64'(re_total - re_mark), 64'd1);
    check_eq("bp_dump_bytes", 64'(tx_total - tx_mark), 64'(DumpBytes));
`ifdef DU_CYCLE_COUNT_EN
    check_eq("bp_cycle_count_lsb", 64'(tx_log[tx_log.size() - 1]), 64'h01);
`endif

    check_eq("no_extra_tx", 64'(tx_extra), 64'd0);
    check_eq("no_extra_writes", 64'(wr_extra), 64'd0);
    check_eq("no_rd_wr_overlap", 64'(overlap), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
